// File: rtl/linescanner_capture_controller_pkg.sv
// Shared definitions for the line-scanner capture path: pixel width, controller state
// encoding and small elaboration-time helpers.
package linescanner_capture_controller_pkg;

  localparam int PIXEL_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/capture_cycle_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare; it saturates at
// the terminal value so a caller that forgets to reload it never sees a wrap.
module capture_cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  assign at_terminal = (count == terminal);

  // NOTE: sequential state is written only with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !at_terminal) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/linescanner_capture_controller.sv
// Frame sequencer for the line-scanner capture unit: gates the unit line by line, counts
// pixels and lines, and forwards accepted pixels as a sol/eol/eof-marked stream.
module linescanner_capture_controller
  import linescanner_capture_controller_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 256,
  parameter int LINES_PER_FRAME = 8,
  parameter int LINE_GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                   main_clock_source,
  input  logic                   n_reset,
  input  logic                   start,
  input  logic                   stop,
  output logic                   capture_enable,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic                   pixel_captured,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_sol,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int PCW = $clog2(PIXELS_PER_LINE);
  localparam int LCW = $clog2(LINES_PER_FRAME + 1);
  localparam int TW  = $clog2(max_int(TIMEOUT_CYCLES, LINE_GAP_CYCLES));

  localparam logic [PCW-1:0] LAST_PIXEL = PCW'(PIXELS_PER_LINE - 1);
  localparam logic [LCW-1:0] LAST_LINE  = LCW'(LINES_PER_FRAME - 1);
  localparam logic [TW-1:0]  GAP_LAST   = TW'(LINE_GAP_CYCLES - 1);
  localparam logic [TW-1:0]  WDOG_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e          state, state_d;
  logic [PCW-1:0]  pixel_cnt;
  logic [LCW-1:0]  line_cnt;
  logic [TW-1:0]   timer_cnt, timer_terminal;
  logic            timer_at_term;

  logic accept, enable_d, done_d;
  logic pix_clr, pix_inc, line_clr, line_inc;
  logic tmr_clear, tmr_load, tmr_inc;
  logic set_err, clr_err;

  wire last_pixel = (pixel_cnt == LAST_PIXEL);
  wire last_line  = (line_cnt == LAST_LINE);

  // One timer serves both the inter-line gap and the pixel watchdog; only the limit differs.
  assign timer_terminal = (state == ST_GAP) ? GAP_LAST : WDOG_LAST;

  capture_cycle_timer #(.WIDTH(TW)) u_timer (
    .clk         (main_clock_source),
    .rst_n       (n_reset),
    .clear       (tmr_clear),
    .load        (tmr_load),
    .load_value  ('0),
    .enable      (tmr_inc),
    .terminal    (timer_terminal),
    .count       (timer_cnt),
    .at_terminal (timer_at_term)
  );

  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state;
    enable_d  = capture_enable;
    accept    = 1'b0;
    done_d    = 1'b0;
    pix_clr   = 1'b0;
    pix_inc   = 1'b0;
    line_clr  = 1'b0;
    line_inc  = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;

    if (state != ST_IDLE && stop) begin
      state_d   = ST_IDLE;
      enable_d  = 1'b0;
      pix_clr   = 1'b0 | 1'b1;
      line_clr  = 1'b1;
      tmr_clear = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          enable_d = 1'b0;
          if (start && !stop) begin
            state_d  = ST_ARM;
            line_clr = 1'b1;
            clr_err  = 1'b1;
          end
        end
        ST_ARM: begin
          state_d  = ST_CAPTURE;
          enable_d = 1'b1;
          pix_clr  = 1'b1;
          tmr_load = 1'b1;
        end
        ST_CAPTURE: begin
          if (pixel_captured) begin
            accept   = 1'b1;
            tmr_load = 1'b1;
            if (last_pixel) begin
              state_d  = ST_GAP;
              enable_d = 1'b0;
              pix_clr  = 1'b1;
            end else begin
              pix_inc = 1'b1;
            end
          end else if (timer_at_term) begin
            state_d   = ST_IDLE;
            enable_d  = 1'b0;
            set_err   = 1'b1;
            pix_clr   = 1'b1;
            line_clr  = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_GAP: begin
          // The unit's trailing pixel lands here and is simply not accepted.
          if (timer_at_term) begin
            tmr_load = 1'b1;
            if (last_line) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_ARM;
              line_inc = 1'b1;
            end
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) begin
      capture_enable <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_sol        <= 1'b0;
      out_eol        <= 1'b0;
      out_eof        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      timeout_err    <= 1'b0;
      pixel_cnt      <= '0;
      line_cnt       <= '0;
    end else begin
      capture_enable <= enable_d;
      busy           <= (state_d != ST_IDLE);
      frame_done     <= done_d;
      out_valid      <= accept;
      out_sol        <= accept && (pixel_cnt == '0);
      out_eol        <= accept && last_pixel;
      out_eof        <= accept && last_pixel && last_line;
      if (accept) out_data <= pixel_data;

      if (pix_clr)      pixel_cnt <= '0;
      else if (pix_inc) pixel_cnt <= pixel_cnt + PCW'(1);

      if (line_clr)      line_cnt <= '0;
      else if (line_inc) line_cnt <= line_cnt + LCW'(1);

      if (set_err)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_linescanner_capture_controller.sv
// Bench for linescanner_capture_controller: a behavioural capture-unit source, a stream
// monitor, and directed plus randomized frames checked against an expected-frame model.
module tb_linescanner_capture_controller;

  localparam int P = 4;
  localparam int L = 2;
  localparam int G = 3;
  localparam int T = 16;

  logic       main_clock_source = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pixel_captured = 1'b0;
  logic [7:0] pixel_data = 8'h00;
  logic       capture_enable, out_valid, out_sol, out_eol, out_eof;
  logic       busy, frame_done, timeout_err;
  logic [7:0] out_data;

  linescanner_capture_controller #(
    .PIXELS_PER_LINE (P),
    .LINES_PER_FRAME (L),
    .LINE_GAP_CYCLES (G),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .main_clock_source (main_clock_source),
    .n_reset           (n_reset),
    .start             (start),
    .stop              (stop),
    .capture_enable    (capture_enable),
    .pixel_data        (pixel_data),
    .pixel_captured    (pixel_captured),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_sol           (out_sol),
    .out_eol           (out_eol),
    .out_eof           (out_eof),
    .busy              (busy),
    .frame_done        (frame_done),
    .timeout_err       (timeout_err)
  );

  initial forever #5 main_clock_source = ~main_clock_source;

  typedef struct packed {
    logic [7:0] data;
    logic       sol;
    logic       eol;
    logic       eof;
  } beat_t;

  beat_t got[$];
  int    cycle = 0, done_count = 0, done_cycle = 0, eof_cycle = 0, done_wide = 0;
  int    src_count = 0, en_cycles = 0;
  logic  prev_done = 1'b0;
  int    tests = 0, fails = 0;

  logic       src_on = 1'b1;
  logic       src_stall = 1'b0;
  logic [7:0] src_base = 8'h00;

  // Capture unit: one cycle of enable latency, counts up from src_base while enabled and
  // restarts from zero once enable is seen low (so it emits one trailing pixel per line).
  initial begin : capture_unit
    logic en_s;
    logic stall_now;
    int   cnt;
    int   stalls;
    cnt = 0;
    stalls = 0;
    forever begin
      @(negedge main_clock_source);
      en_s = capture_enable;
      @(posedge main_clock_source);
      #1;
      stall_now = src_stall && (stalls < 3) && ($urandom_range(0, 3) == 0);
      if (en_s && src_on && !stall_now) begin
        pixel_captured = 1'b1;
        pixel_data     = src_base + 8'(cnt);
        cnt++;
        stalls = 0;
      end else begin
        pixel_captured = 1'b0;
        if (en_s) stalls++;
        else begin
          cnt = 0;
          stalls = 0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge main_clock_source);
      cycle++;
      if (out_valid) begin
        got.push_back({out_data, out_sol, out_eol, out_eof});
        if (out_eof) eof_cycle = cycle;
      end
      if (frame_done) begin
        done_count++;
        done_cycle = cycle;
        if (prev_done) done_wide++;
      end
      prev_done = frame_done;
      if (pixel_captured) src_count++;
      if (capture_enable) en_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge main_clock_source);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_obs();
    got.delete();
    done_count = 0;
    done_wide  = 0;
    src_count  = 0;
    en_cycles  = 0;
  endtask

  function automatic logic [31:0] outputs_packed();
    return 32'({capture_enable, out_data, out_valid, out_sol, out_eol, out_eof,
                busy, frame_done, timeout_err});
  endfunction

  // Expected frame: every line carries base+0 .. base+P-1 with sol/eol/eof markers.
  task automatic expect_frame(input logic [7:0] base, input string tag);
    beat_t exp;
    int    n;
    check({tag, "_beats"}, 32'(got.size()), 32'(P * L));
    n = (got.size() < P * L) ? got.size() : P * L;
    for (int i = 0; i < n; i++) begin
      exp.data = base + 8'(i % P);
      exp.sol  = (i % P) == 0;
      exp.eol  = (i % P) == P - 1;
      exp.eof  = exp.eol && (i / P) == L - 1;
      check($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp));
    end
  endtask

  task automatic run_frame(input logic [7:0] base, input logic stalls, input logic strays,
                           input string tag);
    src_base  = base;
    src_stall = stalls;
    src_on    = 1'b1;
    clear_obs();
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_err_cleared"}, 32'(timeout_err), 32'd0);
    for (int c = 0; c < 400 && done_count == 0; c++) begin
      if (strays && busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        step(1);
        start = 1'b0;
      end else begin
        step(1);
      end
    end
    step(4);
    expect_frame(base, tag);
    check({tag, "_done_count"}, 32'(done_count), 32'd1);
    check({tag, "_done_width"}, 32'(done_wide), 32'd0);
    check({tag, "_done_after_eof"}, 32'(done_cycle - eof_cycle), 32'(G));
    check({tag, "_idle_after"}, 32'({busy, capture_enable, timeout_err}), 32'd0);
    if (!stalls) check({tag, "_source_pixels"}, 32'(src_count), 32'(L * (P + 1)));
  endtask

  initial begin : stimulus
    logic [7:0] base;
    logic       found;

    // Reset state.
    step(3);
    check("reset_outputs", outputs_packed(), 32'd0);
    @(negedge main_clock_source);
    n_reset = 1'b1;
    step(2);
    check("post_reset_outputs", outputs_packed(), 32'd0);

    // Directed frame: data 0,1,2,3,0,1,2,3 with trailing pixel discarded.
    run_frame(8'h00, 1'b0, 1'b0, "frame0");

    // start and stop together in IDLE: nothing happens.
    clear_obs();
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    step(10);
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_beats", 32'(got.size()), 32'd0);
    check("startstop_enable_cycles", 32'(en_cycles), 32'd0);

    // stop on the second pixel of line 0.
    base      = 8'($urandom);
    src_base  = base;
    src_stall = 1'b0;
    clear_obs();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge main_clock_source);
      #2;
      if (pixel_captured && pixel_data == base + 8'd1) found = 1'b1;
    end
    check("stop_pixel_seen", 32'(found), 32'd1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_enable_low", 32'(capture_enable), 32'd0);
    check("stop_busy_low", 32'(busy), 32'd0);
    step(20);
    check("stop_beats", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("stop_first_beat", 32'(got[0]), 32'({base, 1'b1, 1'b0, 1'b0}));
    check("stop_no_done", 32'(done_count), 32'd0);
    check("stop_err_unchanged", 32'(timeout_err), 32'd0);

    // Watchdog: source held silent.
    src_on = 1'b0;
    clear_obs();
    pulse_start();
    for (int c = 0; c < 100 && !timeout_err; c++) step(1);
    step(2);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_capture_cycles", 32'(en_cycles), 32'(T));
    check("timeout_no_done", 32'(done_count), 32'd0);
    check("timeout_no_beats", 32'(got.size()), 32'd0);

    // Next start clears the error; stray starts while busy must not disturb the frame.
    run_frame(8'($urandom), 1'b1, 1'b1, "after_timeout");

    // Asynchronous reset mid-line.
    base      = 8'($urandom);
    src_base  = base;
    src_stall = 1'b0;
    clear_obs();
    pulse_start();
    for (int c = 0; c < 100 && got.size() < P + 2; c++) step(1);
    @(posedge main_clock_source);
    #3;
    n_reset = 1'b0;
    #1;
    check("async_reset_outputs", outputs_packed(), 32'd0);
    @(negedge main_clock_source);
    @(negedge main_clock_source);
    n_reset = 1'b1;
    step(2);
    check("after_reset_idle", outputs_packed(), 32'd0);
    run_frame(8'($urandom), 1'b0, 1'b0, "after_reset");

    // Randomized frames with source stalls and stray starts.
    for (int f = 0; f < 3; f++) run_frame(8'($urandom), 1'b1, 1'b1, $sformatf("rand%0d", f));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
